// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed memory of DEPTH words.
// Read and write channels run as independent FSMs, each with at most one
// burst in flight. Bursts that are WRAP, reserved or narrower/wider than
// the bus report SLVERR and never touch memory. Beats that fall outside
// the memory window are dropped and also report SLVERR.
module axi4_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_RID,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Whole-burst error: only FIXED/INCR at full bus width are serviced.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != 3'(SH));
  endfunction

  // Per-beat error: address below the window or word index past the end.
  function automatic logic beat_oob(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || ((off >> SH) >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = (a - BASE_ADDR) >> SH;
    return w[IDX_W-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + ADDR_WIDTH'(BYTES) : a;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t              w_state;
  logic                  awready_r, wready_r, bvalid_r;
  logic [1:0]            bresp_r;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_berr, w_err;

  r_state_t              r_state;
  logic                  arready_r, rvalid_r, rlast_r;
  logic [1:0]            rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_berr;

  logic                  w_beat, w_oob, w_final, w_lerr, mem_we;
  logic                  ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_berr, ld_bad;
  logic [DATA_WIDTH-1:0] ld_word;

  // The W phase is closed by the beat count; WLAST only grades the response.
  assign w_beat  = wready_r && S_AXI_WVALID;
  assign w_oob   = beat_oob(w_addr);
  assign w_final = (w_cnt == w_len);
  assign w_lerr  = (S_AXI_WLAST != w_final);
  assign mem_we  = w_beat && !w_berr && !w_oob;

  assign ar_hs = arready_r && S_AXI_ARVALID;
  assign r_hs  = rvalid_r && S_AXI_RREADY;

  // Address of the beat loaded into the R registers on this edge: the AR
  // address for the first beat, the successor of the presented beat after.
  assign ld_addr = (r_state == R_IDLE) ? S_AXI_ARADDR : next_addr(r_addr, r_burst);
  assign ld_berr = (r_state == R_IDLE) ? burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE) : r_berr;
  assign ld_bad  = ld_berr || beat_oob(ld_addr);

  // Combinational memory read; a write on the same edge lands afterwards,
  // so a colliding read observes the old word.
  always_comb begin
    ld_word = '0;
    if (!ld_bad) ld_word = mem[word_idx(ld_addr)];
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Write FSM: AW accept, count AWLEN+1 beats, then hold B until taken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      aw_id     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_berr    <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          awready_r <= 1'b1;
          if (awready_r && S_AXI_AWVALID) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            aw_id     <= S_AXI_AWID;
            w_addr    <= S_AXI_AWADDR;
            w_len     <= S_AXI_AWLEN;
            w_burst   <= S_AXI_AWBURST;
            w_berr    <= burst_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= next_addr(w_addr, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err | w_oob | w_lerr;
            if (w_final) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              bresp_r  <= (w_berr | w_err | w_oob | w_lerr) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: first beat registered on the AR edge, each later beat on the
  // edge that retires the previous one; outputs hold while stalled.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= '0;
      ar_id     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_berr    <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          arready_r <= 1'b1;
          if (ar_hs) begin
            arready_r <= 1'b0;
            ar_id     <= S_AXI_ARID;
            r_addr    <= S_AXI_ARADDR;
            r_len     <= S_AXI_ARLEN;
            r_burst   <= S_AXI_ARBURST;
            r_berr    <= ld_berr;
            r_cnt     <= '0;
            rvalid_r  <= 1'b1;
            rdata_r   <= ld_word;
            rresp_r   <= ld_bad ? RESP_SLVERR : RESP_OKAY;
            rlast_r   <= (S_AXI_ARLEN == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_addr  <= ld_addr;
              r_cnt   <= r_cnt + 8'd1;
              rdata_r <= ld_word;
              rresp_r <= ld_bad ? RESP_SLVERR : RESP_OKAY;
              rlast_r <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_BID     = aw_id;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RID     = ar_id;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: directed vector table, multi-cycle corner
// sequences, and randomized bursts scored against an array-based model.
module tb_axi4_slave_mem;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          IW    = 4;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [IW-1:0] AWID = '0;
  logic [AW-1:0] AWADDR = '0;
  logic [7:0]    AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic [1:0]    AWBURST = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WLAST = 1'b0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [IW-1:0] ARID = '0;
  logic [AW-1:0] ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic [2:0]    ARSIZE = '0;
  logic [1:0]    ARBURST = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi4_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY),
    .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
    .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdata_q [$];
  logic [3:0]  wstrb_q [$];
  logic [31:0] got_data [$];
  logic [1:0]  got_resp [$];
  logic        got_last [$];
  logic [IW-1:0] got_id;
  logic [1:0]    got_bresp;
  logic [IW-1:0] got_bid;

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    return (b == 2'b01) ? a + 32'(4 * i) : a;
  endfunction

  function automatic bit m_oob(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) / 4) >= 32'(DEPTH));
  endfunction

  function automatic bit m_burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (burst > 2'b01) || (size != 3'd2);
  endfunction

  // Apply a burst to the model; returns the expected BRESP.
  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int wlast_at);
    bit err, any;
    logic [31:0] ba;
    err = m_burst_err(size, burst);
    any = err || (wlast_at != int'(len));
    for (int i = 0; i <= int'(len); i++) begin
      ba = m_addr(a, burst, i);
      if (m_oob(ba)) any = 1'b1;
      else if (!err) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_q[i][b]) ref_mem[(ba - BASE) / 4][8*b +: 8] = wdata_q[i][8*b +: 8];
      end
    end
    return any ? 2'b10 : 2'b00;
  endfunction

  task automatic check_read(input logic [IW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit bad;
    logic [31:0] ba, ed;
    check("r_beat_count", 64'(got_data.size()), 64'(int'(len) + 1));
    if (got_data.size() > 0) check("rid", 64'(got_id), 64'(id));
    for (int i = 0; i < got_data.size() && i <= int'(len); i++) begin
      ba  = m_addr(a, burst, i);
      bad = m_burst_err(size, burst) || m_oob(ba);
      ed  = bad ? 32'h0 : ref_mem[(ba - BASE) / 4];
      check($sformatf("rdata[%0d]@%0h", i, a), 64'(got_data[i]), 64'(ed));
      check($sformatf("rresp[%0d]@%0h", i, a), 64'(got_resp[i]), bad ? 64'd2 : 64'd0);
      check($sformatf("rlast[%0d]@%0h", i, a), 64'(got_last[i]), 64'(i == int'(len)));
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
    int t;
    @(negedge ACLK);
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 200) begin @(negedge ACLK); t++; end
    if (t >= 200) begin fail_now("aw_wait"); AWVALID = 1'b0; return; end
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    check("awready_low_in_burst", 64'(AWREADY), 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wdata_q[i]; WSTRB = wstrb_q[i]; WLAST = (i == wlast_at); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 200) begin @(negedge ACLK); t++; end
      if (t >= 200) begin fail_now("w_wait"); WVALID = 1'b0; return; end
      @(posedge ACLK); @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 200) begin @(negedge ACLK); t++; end
    if (t >= 200) begin fail_now("b_wait"); BREADY = 1'b0; return; end
    got_bresp = BRESP; got_bid = BID;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] pat, input int pre);
    int t, cyc;
    bit done, stalled;
    logic [34:0] prev;
    got_data.delete(); got_resp.delete(); got_last.delete();
    @(negedge ACLK);
    repeat (pre) @(negedge ACLK);
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 200) begin @(negedge ACLK); t++; end
    if (t >= 200) begin fail_now("ar_wait"); ARVALID = 1'b0; return; end
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    t = 0; cyc = 0; done = 1'b0; stalled = 1'b0; prev = '0;
    while (!done && t < 600) begin
      RREADY = pat[cyc % 4];
      check("rvalid_held", 64'(RVALID), 64'd1);
      if (!RVALID) break;
      if (stalled) check("r_stable_when_stalled", 64'({RDATA, RRESP, RLAST}), 64'(prev));
      stalled = !RREADY;
      prev = {RDATA, RRESP, RLAST};
      if (RREADY) begin
        got_data.push_back(RDATA); got_resp.push_back(RRESP); got_last.push_back(RLAST);
        if (got_data.size() == 1) got_id = RID;
        done = RLAST || (got_data.size() > int'(len) + 1);
      end
      @(posedge ACLK); @(negedge ACLK);
      cyc++; t++;
    end
    RREADY = 1'b0;
    if (!done) fail_now("r_burst_end");
    else begin
      check("rvalid_after_last", 64'(RVALID), 64'd0);
      check("arready_after_last", 64'(ARREADY), 64'd1);
    end
  endtask

  task automatic load_data(input logic [7:0] len, input logic [31:0] d0, input logic [31:0] step,
                           input logic [3:0] strb);
    wdata_q.delete(); wstrb_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      wdata_q.push_back(d0 + step * 32'(i));
      wstrb_q.push_back(strb);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] d0;
    logic [31:0] step;
    logic [3:0]  strb;
    int          wlast_at;
    logic [1:0]  resp;
    bit          chk_d;
    logic [31:0] d_exp;
  } vec_t;

  vec_t vq [$];

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] d0, input logic [31:0] step, input logic [3:0] strb,
                              input int wlast_at, input logic [1:0] resp, input bit chk_d,
                              input logic [31:0] d_exp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.d0 = d0;
    v.step = step; v.strb = strb; v.wlast_at = wlast_at; v.resp = resp; v.chk_d = chk_d;
    v.d_exp = d_exp;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    er;
    logic [IW-1:0] id;
    logic [31:0]   a, old_word;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    int            wl, hs, t;

    // Reset values while ARESET is held
    repeat (3) @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_wready",  64'(WREADY), 64'd0);
    check("rst_bvalid",  64'(BVALID), 64'd0);
    check("rst_rvalid",  64'(RVALID), 64'd0);
    check("rst_rlast",   64'(RLAST), 64'd0);
    check("rst_resp_ids_rdata", 64'({BRESP, RRESP, BID, RID, RDATA}), 64'd0);
    ARESET = 1'b0;
    #1 check("awready_before_first_clk", 64'(AWREADY), 64'd0);
    @(negedge ACLK);
    check("awready_after_release", 64'(AWREADY), 64'd1);
    check("arready_after_release", 64'(ARREADY), 64'd1);

    // Fill the whole memory with a 256-beat INCR burst
    load_data(8'd255, 32'h5A00_0000, 32'h1, 4'hF);
    er = model_write(32'h0, 8'd255, 3'd2, 2'b01, 255);
    do_write(4'h9, 32'h0, 8'd255, 3'd2, 2'b01, 255);
    check("fill256_bresp", 64'(got_bresp), 64'(er));
    check("fill256_bid", 64'(got_bid), 64'h9);

    vq.push_back(mk(1, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 32'h1, 4'hF, 3, 2'b00, 0, 32'h0));
    vq.push_back(mk(0, 32'h10, 8'd3, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'hA0));
    vq.push_back(mk(1, 32'h20, 8'd1, 3'd2, 2'b00, 32'h11, 32'h11, 4'hF, 1, 2'b00, 0, 32'h0));
    vq.push_back(mk(0, 32'h20, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'h22));
    vq.push_back(mk(1, 32'h30, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 0, 4'hF, 0, 2'b00, 0, 32'h0));
    vq.push_back(mk(1, 32'h30, 8'd0, 3'd2, 2'b01, 32'h0, 0, 4'h5, 0, 2'b00, 0, 32'h0));
    vq.push_back(mk(0, 32'h30, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'hFF00_FF00));
    vq.push_back(mk(1, 32'h3FC, 8'd1, 3'd2, 2'b01, 32'hC0, 32'h1, 4'hF, 1, 2'b10, 0, 32'h0));
    vq.push_back(mk(0, 32'h3FC, 8'd1, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'hC0));
    vq.push_back(mk(1, 32'h40, 8'd3, 3'd2, 2'b01, 32'hB0, 32'h1, 4'hF, 1, 2'b10, 0, 32'h0));
    vq.push_back(mk(0, 32'h40, 8'd3, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'hB0));
    vq.push_back(mk(1, 32'h50, 8'd1, 3'd2, 2'b10, 32'hD0, 32'h1, 4'hF, 1, 2'b10, 0, 32'h0));
    vq.push_back(mk(0, 32'h50, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'h5A00_0014));
    vq.push_back(mk(0, 32'h50, 8'd0, 3'd1, 2'b01, 0, 0, 0, 0, 2'b10, 1, 32'h0));
    vq.push_back(mk(0, 32'h400, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b10, 1, 32'h0));
    vq.push_back(mk(1, 32'h60, 8'd0, 3'd0, 2'b01, 32'h77, 0, 4'hF, 0, 2'b10, 0, 32'h0));
    vq.push_back(mk(0, 32'h60, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 1, 32'h5A00_0018));

    for (int k = 0; k < vq.size(); k++) begin
      vec_t v;
      v = vq[k];
      id = 4'(k);
      if (v.wr) begin
        load_data(v.len, v.d0, v.step, v.strb);
        void'(model_write(v.addr, v.len, v.size, v.burst, v.wlast_at));
        do_write(id, v.addr, v.len, v.size, v.burst, v.wlast_at);
        check($sformatf("vec%0d_bresp", k), 64'(got_bresp), 64'(v.resp));
        check($sformatf("vec%0d_bid", k), 64'(got_bid), 64'(id));
      end else begin
        do_read(id, v.addr, v.len, v.size, v.burst, 4'hF, 0);
        if (got_data.size() > 0) begin
          check($sformatf("vec%0d_rresp0", k), 64'(got_resp[0]), 64'(v.resp));
          if (v.chk_d) check($sformatf("vec%0d_rdata0", k), 64'(got_data[0]), 64'(v.d_exp));
        end
        check_read(id, v.addr, v.len, v.size, v.burst);
      end
    end

    // Eight-beat read with RREADY pattern 1,0,0,1 repeating
    load_data(8'd7, 32'hE0, 32'h1, 4'hF);
    er = model_write(32'h80, 8'd7, 3'd2, 2'b01, 7);
    do_write(4'h3, 32'h80, 8'd7, 3'd2, 2'b01, 7);
    check("stall_setup_bresp", 64'(got_bresp), 64'(er));
    do_read(4'h4, 32'h80, 8'd7, 3'd2, 2'b01, 4'b1001, 0);
    check_read(4'h4, 32'h80, 8'd7, 3'd2, 2'b01);

    // Write beat and first read beat on the same word, same edge
    old_word = ref_mem[36];
    load_data(8'd0, 32'h1234_5678, 32'h0, 4'hF);
    fork
      do_write(4'h6, 32'h90, 8'd0, 3'd2, 2'b01, 0);
      do_read(4'h7, 32'h90, 8'd0, 3'd2, 2'b01, 4'hF, 1);
    join
    if (got_data.size() > 0) check("collision_old_data", 64'(got_data[0]), 64'(old_word));
    else fail_now("collision_read");
    er = model_write(32'h90, 8'd0, 3'd2, 2'b01, 0);
    check("collision_bresp", 64'(got_bresp), 64'(er));
    do_read(4'h7, 32'h90, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    check_read(4'h7, 32'h90, 8'd0, 3'd2, 2'b01);

    // Reset while beat 3 of an 8-beat read is on the bus
    @(negedge ACLK);
    ARID = 4'h5; ARADDR = 32'h80; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    hs = 0; t = 0;
    while (hs < 2 && t < 50) begin
      if (RVALID) hs++;
      @(posedge ACLK); @(negedge ACLK);
      t++;
    end
    if (hs < 2) fail_now("rst_mid_read_beats");
    check("rst_mid_beat3_data", 64'(RDATA), 64'(ref_mem[34]));
    check("rst_mid_beat3_valid", 64'(RVALID), 64'd1);
    #2 ARESET = 1'b1;
    #1;
    check("rst_mid_rvalid_async", 64'(RVALID), 64'd0);
    check("rst_mid_arready", 64'(ARREADY), 64'd0);
    check("rst_mid_rdata", 64'({RDATA, RLAST}), 64'd0);
    RREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_mid_arready_back", 64'(ARREADY), 64'd1);
    do_read(4'h8, 32'h80, 8'd3, 3'd2, 2'b01, 4'hF, 0);
    check_read(4'h8, 32'h80, 8'd3, 3'd2, 2'b01);

    // Randomized bursts against the model
    for (int n = 0; n < 60; n++) begin
      id    = 4'($urandom);
      a     = 32'($urandom_range(0, DEPTH + 8)) * 32'd4;
      len   = 8'($urandom_range(0, 7));
      burst = ($urandom % 8 == 0) ? 2'b10 : 2'($urandom % 2);
      size  = ($urandom % 10 == 0) ? 3'd1 : 3'd2;
      if ($urandom % 2 == 0) begin
        wdata_q.delete(); wstrb_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
          wdata_q.push_back($urandom);
          wstrb_q.push_back(4'($urandom));
        end
        wl = ($urandom % 8 == 0) ? int'($urandom_range(0, 7)) : int'(len);
        er = model_write(a, len, size, burst, wl);
        do_write(id, a, len, size, burst, wl);
        check($sformatf("rand%0d_bresp", n), 64'(got_bresp), 64'(er));
        check($sformatf("rand%0d_bid", n), 64'(got_bid), 64'(id));
      end else begin
        do_read(id, a, len, size, burst, 4'($urandom) | 4'b0001, 0);
        check_read(id, a, len, size, burst);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (32 or 64).
- ID_WIDTH, 4, transaction ID width.
- DEPTH, 1024, memory words.
- BASE_ADDR, 0, byte address of word 0.

REQ-002 Ports SHALL be:
- ACLK  in  1  clock; one clock, all logic on its rising edge.
- ARESET  in  1  reset; asynchronous and active-high.
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  read address channel.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.

Function
REQ-003 Read and write paths SHALL be independent FSMs, each with at most one outstanding burst.
REQ-004 Write FSM SHALL have states W_IDLE (AWREADY=1), W_DATA (WREADY=1), and W_RESP (BVALID=1).
- W_IDLE->W_DATA on the AW handshake.
- W_DATA->W_RESP on the write beat numbered AWLEN+1.
- W_RESP->W_IDLE on the B handshake.
REQ-005 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
- R_IDLE->R_DATA on the AR handshake.
- R_DATA->R_IDLE on the R handshake with RLAST=1.
REQ-006 On an AW or AR handshake, the block SHALL latch ID, address, LEN, SIZE and BURST, and clear its beat counter.
REQ-007 Word index SHALL be (addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
REQ-008 The word index SHALL advance by 1 per beat for INCR (2'b01) and stay constant for FIXED (2'b00).
REQ-009 WRAP and reserved bursts, and any SIZE other than log2(DATA_WIDTH/8), SHALL mark the burst as an error. An errored burst completes its full handshake with no memory write, and its read data is 0.
REQ-010 A beat whose address is below BASE_ADDR or whose word index is DEPTH or more SHALL be discarded; reads of such a beat return 0. Each such beat marks the burst as an error.
REQ-011 Write beats SHALL update only the bytes whose WSTRB bit is set.
REQ-012 The write response SHALL report SLVERR (2'b10) on error, otherwise OKAY (2'b00):
- BRESP=SLVERR if any beat of the burst errored, or if WLAST does not match the final counted beat.
- The W phase ends on the beat count, never on WLAST.
REQ-013 BID SHALL equal the latched AWID, and RID SHALL equal the latched ARID.
REQ-014 Read latency:
- The first RVALID SHALL be asserted the cycle after the AR handshake.
- Each next beat SHALL be presented the cycle after the previous R handshake.
- RDATA, RRESP and RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-015 RRESP SHALL be SLVERR for each errored read beat, otherwise OKAY.
REQ-016 RLAST SHALL be 1 only on the beat numbered ARLEN+1.
REQ-017 If a write and a read hit the same word in the same cycle, the read beat being loaded SHALL return the pre-write data.
REQ-018 AWLEN=0 and ARLEN=0 SHALL produce single-beat bursts, and AWLEN=255 SHALL accept 256 beats.
REQ-019 The block SHALL NOT assert AWREADY again until B completes, and SHALL NOT assert ARREADY again until RLAST completes.

Reset
REQ-020 While ARESET=1, at any time including mid-burst, both FSMs SHALL go to their idle state.
REQ-021 Reset values SHALL be:
- AWREADY=0 and ARREADY=0 while ARESET=1, and 1 from the first clock after release.
- WREADY, BVALID, RVALID and RLAST = 0.
- BRESP, RRESP, BID, RID and RDATA = 0.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 A burst interrupted by reset SHALL be abandoned with no response, and any beats it already wrote SHALL remain in memory.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- INCR write AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF -> BRESP=OKAY, BID=AWID; INCR read of the same -> 0xA0..0xA3 with RLAST on beat 4 only.
- FIXED write AWADDR=0x20, AWLEN=1, data 0x11 then 0x22 -> read of word 8 returns 0x22.
- Write 0xFFFFFFFF, then write 0x00000000 with WSTRB=0x5 -> read returns 0xFF00FF00.
- AWADDR=(DEPTH-1)*4, AWLEN=1 -> beat 1 written, beat 2 discarded, BRESP=SLVERR; read over the same range -> RRESP OKAY then SLVERR.
- Read AWLEN=7 with RREADY toggling 1,0,0,1... -> RDATA stable while stalled, exactly 8 beats; WLAST asserted on beat 2 of AWLEN=3 -> BRESP=SLVERR after 4 beats.
- Reset asserted mid-read on beat 3 -> RVALID=0 asynchronously, ARREADY=1 the cycle after release, and the next burst behaves normally.
